// File: rtl/spi_slave_frame_rx.sv
// Oversampled SPI mode-0 slave that reassembles fixed-length CS_N frames into one payload sample.
// Optional feature: define SPI_RX_PAD_CHECK_EN to reject frames whose padding bytes differ from PAD_BYTE.
module spi_slave_frame_rx #(
  parameter int         FRAME_BYTES   = 8,
  parameter int         PAYLOAD_BYTES = 6,
  parameter logic [7:0] PAD_BYTE      = 8'hAB,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic                         CLK100MHZ,
  input  logic                         RESET_N,
  input  logic                         SPI_CS_N,
  input  logic                         SPI_SCLK,
  input  logic                         SPI_MOSI,
  output logic                         SPI_MISO,
  output logic [8*PAYLOAD_BYTES-1:0]   o_frame_data,
  output logic                         o_frame_valid,
  output logic                         o_frame_err,
  output logic [15:0]                  o_frame_count,
  output logic                         o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  localparam int         DATA_W      = 8 * PAYLOAD_BYTES;
  localparam int         LAST        = SYNC_STAGES - 1;
  localparam logic [3:0] FRAME_CNT   = 4'(FRAME_BYTES);
  localparam logic [3:0] PAYLOAD_CNT = 4'(PAYLOAD_BYTES);
`ifdef SPI_RX_PAD_CHECK_EN
  localparam logic       PAD_CHECK_ON = 1'b1;
`else
  localparam logic       PAD_CHECK_ON = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   cs_prev_r;
  logic                   sclk_prev_r;
  logic                   cs_lvl_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;

  state_t                 state_r;
  state_t                 next_state_s;
  logic                   start_s;
  logic                   rx_en_s;
  logic                   accept_s;
  logic                   reject_s;
  logic                   frame_good_s;

  logic [2:0]             bit_cnt_r;
  logic [3:0]             byte_cnt_r;
  logic                   overflow_r;
  logic                   pad_err_r;
  logic [6:0]             shift_r;
  logic [7:0]             rx_byte_s;
  logic                   pad_bad_s;
  logic [7:0]             last_rx_byte_r;
  logic [7:0]             frame_buf_r [PAYLOAD_BYTES];

  logic [7:0]             tx_r;
  logic                   miso_r;
  logic [DATA_W-1:0]      data_r;
  logic                   valid_r;
  logic                   err_r;
  logic [15:0]            count_r;
  logic                   busy_r;

  // Pin synchronizers plus one extra sample for edge detection.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_sync_r   <= {SYNC_STAGES{1'b0}};
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      cs_prev_r   <= 1'b0;
      sclk_prev_r <= 1'b0;
    end else begin
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], SPI_CS_N};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SPI_SCLK};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], SPI_MOSI};
      cs_prev_r   <= cs_sync_r[LAST];
      sclk_prev_r <= sclk_sync_r[LAST];
    end
  end

  // CS_N resets to "low" so a CS window already open at reset release never looks like a new frame.
  assign cs_lvl_s    = cs_sync_r[LAST];
  assign cs_fall_s   = cs_prev_r & ~cs_lvl_s;
  assign cs_rise_s   = ~cs_prev_r & cs_lvl_s;
  assign sclk_rise_s = sclk_sync_r[LAST] & ~sclk_prev_r & ~cs_lvl_s;
  assign sclk_fall_s = ~sclk_sync_r[LAST] & sclk_prev_r & ~cs_lvl_s;

  assign rx_byte_s    = {shift_r, mosi_sync_r[LAST]};
  assign pad_bad_s    = PAD_CHECK_ON && (byte_cnt_r >= PAYLOAD_CNT) && (rx_byte_s != PAD_BYTE);
  assign frame_good_s = (bit_cnt_r == 3'd0) && (byte_cnt_r == FRAME_CNT) && !overflow_r && !pad_err_r;

  // FSM state register.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; a CS_N fall during the check cycle starts the next frame directly.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cs_fall_s) next_state_s = S_RECV;
        else           next_state_s = S_IDLE;
      end
      S_RECV: begin
        if (cs_rise_s) next_state_s = S_CHECK;
        else           next_state_s = S_RECV;
      end
      S_CHECK: begin
        if (cs_fall_s) next_state_s = S_RECV;
        else           next_state_s = S_IDLE;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    start_s  = 1'b0;
    rx_en_s  = 1'b0;
    accept_s = 1'b0;
    reject_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        start_s = cs_fall_s;
      end
      S_RECV: begin
        rx_en_s = sclk_rise_s;
      end
      S_CHECK: begin
        start_s = cs_fall_s;
        if (frame_good_s) accept_s = 1'b1;
        else              reject_s = 1'b1;
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // Bit/byte assembly; only payload bytes are kept, padding is checked as it arrives.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt_r      <= 3'd0;
      byte_cnt_r     <= 4'd0;
      overflow_r     <= 1'b0;
      pad_err_r      <= 1'b0;
      shift_r        <= 7'd0;
      last_rx_byte_r <= 8'd0;
      for (int i = 0; i < PAYLOAD_BYTES; i++) frame_buf_r[i] <= 8'd0;
    end else if (start_s) begin
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 4'd0;
      overflow_r <= 1'b0;
      pad_err_r  <= 1'b0;
      shift_r    <= 7'd0;
    end else if (rx_en_s) begin
      shift_r   <= rx_byte_s[6:0];
      bit_cnt_r <= bit_cnt_r + 3'd1;
      if (bit_cnt_r == 3'd7) begin
        last_rx_byte_r <= rx_byte_s;
        if (byte_cnt_r < FRAME_CNT) begin
          for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (byte_cnt_r == 4'(i)) frame_buf_r[i] <= rx_byte_s;
          end
          if (pad_bad_s) pad_err_r <= 1'b1;
        end else begin
          overflow_r <= 1'b1;
        end
        if (byte_cnt_r != 4'hF) byte_cnt_r <= byte_cnt_r + 4'd1;
      end
    end
  end

  // MISO echo: byte n carries byte n-1, reloaded on the first SCLK fall after a byte completes.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_r   <= 8'd0;
      miso_r <= 1'b0;
    end else if (start_s) begin
      tx_r   <= 8'd0;
      miso_r <= 1'b0;
    end else if ((state_r != S_RECV) || cs_lvl_s) begin
      tx_r   <= 8'd0;
      miso_r <= 1'b0;
    end else if (sclk_fall_s) begin
      if (bit_cnt_r == 3'd0) begin
        tx_r   <= {last_rx_byte_r[6:0], 1'b0};
        miso_r <= last_rx_byte_r[7];
      end else begin
        tx_r   <= {tx_r[6:0], 1'b0};
        miso_r <= tx_r[7];
      end
    end
  end

  // Frame result outputs; data and count only move on an accepted frame.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      data_r  <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      count_r <= 16'd0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= accept_s;
      err_r   <= reject_s;
      busy_r  <= (next_state_s == S_RECV);
      if (accept_s) begin
        for (int i = 0; i < PAYLOAD_BYTES; i++) data_r[DATA_W-1-8*i -: 8] <= frame_buf_r[i];
        count_r <= count_r + 16'd1;
      end
    end
  end

  assign SPI_MISO      = miso_r;
  assign o_frame_data  = data_r;
  assign o_frame_valid = valid_r;
  assign o_frame_err   = err_r;
  assign o_frame_count = count_r;
  assign o_busy        = busy_r;

endmodule
